// File: rtl/equiv_checker.sv
// Equivalence checker: compares behavioural vs structural model outputs per sample.
// Optional first-failure capture enabled by defining EQC_FIRST_FAIL_CAPTURE_EN.
module equiv_checker #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int N_VEC = 20,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [N_IN-1:0]  in_vec,
  input  logic [N_OUT-1:0] b_out,
  input  logic [N_OUT-1:0] s_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch_pulse,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [N_IN-1:0]  first_bad_vec,
  output logic [N_OUT-1:0] first_bad_diff
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(N_VEC);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d;
  logic             pulse_q, pulse_d;
  logic [N_OUT-1:0] diff;
  logic             accept;
  logic             fail;

  // XOR with an X/Z operand yields X, so "!== 0" flags unknowns as differences.
  function automatic logic [N_OUT-1:0] diff_mask(input logic [N_OUT-1:0] a,
                                                 input logic [N_OUT-1:0] b);
    logic [N_OUT-1:0] m;
    m = '0;
    for (int i = 0; i < N_OUT; i++) begin
      m[i] = ((a[i] ^ b[i]) !== 1'b0);
    end
    return m;
  endfunction

  always_comb begin
    diff   = diff_mask(b_out, s_out);
    accept = (state_q == RUN) && sample_valid && !start;
    fail   = accept && (|diff);

    state_d   = state_q;
    vec_cnt_d = vec_cnt_q;
    mm_cnt_d  = mm_cnt_q;
    pulse_d   = 1'b0;
    if (start) begin
      state_d   = RUN;
      vec_cnt_d = '0;
      mm_cnt_d  = '0;
    end else if (accept) begin
      vec_cnt_d = vec_cnt_q + 1'b1;
      if ((vec_cnt_q + 1'b1) == LAST_VEC) state_d = DONE;
      if (fail) begin
        pulse_d = 1'b1;
        if (mm_cnt_q != CNT_MAX) mm_cnt_d = mm_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_cnt_q <= '0;
      mm_cnt_q  <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_cnt_q <= vec_cnt_d;
      mm_cnt_q  <= mm_cnt_d;
      pulse_q   <= pulse_d;
    end
  end

`ifdef EQC_FIRST_FAIL_CAPTURE_EN
  logic [N_IN-1:0]  fb_vec_q, fb_vec_d;
  logic [N_OUT-1:0] fb_diff_q, fb_diff_d;

  // Capture only the first failure of a run; later failures leave it untouched.
  always_comb begin
    fb_vec_d  = fb_vec_q;
    fb_diff_d = fb_diff_q;
    if (start) begin
      fb_vec_d  = '0;
      fb_diff_d = '0;
    end else if (fail && (mm_cnt_q == '0)) begin
      fb_vec_d  = in_vec;
      fb_diff_d = diff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_vec_q  <= '0;
      fb_diff_q <= '0;
    end else begin
      fb_vec_q  <= fb_vec_d;
      fb_diff_q <= fb_diff_d;
    end
  end

  assign first_bad_vec  = fb_vec_q;
  assign first_bad_diff = fb_diff_q;
`else
  logic unused_in_vec;
  assign unused_in_vec  = ^in_vec;
  assign first_bad_vec  = '0;
  assign first_bad_diff = '0;
`endif

  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign pass           = (state_q == DONE) && (mm_cnt_q == '0);
  assign mismatch_pulse = pulse_q;
  assign vec_cnt        = vec_cnt_q;
  assign mismatch_cnt   = mm_cnt_q;

endmodule

// File: tb/tb_equiv_checker.sv
// Self-checking bench for equiv_checker: two instances (default and CNT_W=4/N_VEC=15)
// checked every cycle against a sample-list reference model, plus vector table and corner sequences.
module tb_equiv_checker;

`ifdef EQC_FIRST_FAIL_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, sample_valid;
  logic [3:0] in_vec;
  logic [1:0] b_out, s_out;

  logic       a_busy, a_done, a_pass, a_pulse;
  logic [7:0] a_vc, a_mm;
  logic [3:0] a_fv;
  logic [1:0] a_fd;
  logic       z_busy, z_done, z_pass, z_pulse;
  logic [3:0] z_vc, z_mm;
  logic [3:0] z_fv;
  logic [1:0] z_fd;

  equiv_checker #(.N_IN(4), .N_OUT(2), .N_VEC(20), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .in_vec(in_vec), .b_out(b_out), .s_out(s_out),
    .busy(a_busy), .done(a_done), .pass(a_pass), .mismatch_pulse(a_pulse),
    .vec_cnt(a_vc), .mismatch_cnt(a_mm), .first_bad_vec(a_fv), .first_bad_diff(a_fd)
  );

  equiv_checker #(.N_IN(4), .N_OUT(2), .N_VEC(15), .CNT_W(4)) dut_z (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .in_vec(in_vec), .b_out(b_out), .s_out(s_out),
    .busy(z_busy), .done(z_done), .pass(z_pass), .mismatch_pulse(z_pulse),
    .vec_cnt(z_vc), .mismatch_cnt(z_mm), .first_bad_vec(z_fv), .first_bad_diff(z_fd)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  // Reference model: per instance, the list of accepted samples' diff masks for this run.
  int         nvec[2] = '{20, 15};
  int         cmax[2] = '{255, 15};
  bit         m_run[2], m_done[2], m_pulse[2];
  logic [1:0] m_diffs0[$];
  logic [1:0] m_diffs1[$];
  logic [3:0] m_vecs0[$];
  logic [3:0] m_vecs1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h expected %0h at t=%0t", phase, name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_diff(input logic [1:0] b, input logic [1:0] s);
    logic [1:0] d;
    for (int i = 0; i < 2; i++) begin
      if ($isunknown(b[i]) || $isunknown(s[i])) d[i] = 1'b1;
      else d[i] = (b[i] != s[i]);
    end
    return d;
  endfunction

  task automatic model_step();
    logic [1:0] d;
    d = ref_diff(b_out, s_out);
    for (int k = 0; k < 2; k++) begin
      m_pulse[k] = 1'b0;
      if (rst || start) begin
        m_run[k]  = start && !rst;
        m_done[k] = 1'b0;
        if (k == 0) begin m_diffs0.delete(); m_vecs0.delete(); end
        else        begin m_diffs1.delete(); m_vecs1.delete(); end
      end else if (m_run[k] && sample_valid) begin
        if (k == 0) begin m_diffs0.push_back(d); m_vecs0.push_back(in_vec); end
        else        begin m_diffs1.push_back(d); m_vecs1.push_back(in_vec); end
        m_pulse[k] = (d != 2'b00);
        if (((k == 0) ? m_diffs0.size() : m_diffs1.size()) == nvec[k]) begin
          m_run[k]  = 1'b0;
          m_done[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic expect_of(input int k, output int acc, output int mm,
                           output logic [3:0] fv, output logic [1:0] fd);
    int nf;
    nf = 0; fv = '0; fd = '0;
    acc = (k == 0) ? m_diffs0.size() : m_diffs1.size();
    for (int i = 0; i < acc; i++) begin
      logic [1:0] d;
      d = (k == 0) ? m_diffs0[i] : m_diffs1[i];
      if (d != 2'b00) begin
        if (nf == 0) begin
          fv = (k == 0) ? m_vecs0[i] : m_vecs1[i];
          fd = d;
        end
        nf++;
      end
    end
    mm = (nf > cmax[k]) ? cmax[k] : nf;
    if (!CAP) begin fv = '0; fd = '0; end
  endtask

  task automatic check_all();
    int acc, mm;
    logic [3:0] fv;
    logic [1:0] fd;
    expect_of(0, acc, mm, fv, fd);
    chk("a.busy",  32'(a_busy),  32'(m_run[0]));
    chk("a.done",  32'(a_done),  32'(m_done[0]));
    chk("a.pass",  32'(a_pass),  32'(m_done[0] && mm == 0));
    chk("a.pulse", 32'(a_pulse), 32'(m_pulse[0]));
    chk("a.vc",    32'(a_vc),    32'(acc));
    chk("a.mm",    32'(a_mm),    32'(mm));
    chk("a.fv",    32'(a_fv),    32'(fv));
    chk("a.fd",    32'(a_fd),    32'(fd));
    expect_of(1, acc, mm, fv, fd);
    chk("z.busy",  32'(z_busy),  32'(m_run[1]));
    chk("z.done",  32'(z_done),  32'(m_done[1]));
    chk("z.pass",  32'(z_pass),  32'(m_done[1] && mm == 0));
    chk("z.pulse", 32'(z_pulse), 32'(m_pulse[1]));
    chk("z.vc",    32'(z_vc),    32'(acc));
    chk("z.mm",    32'(z_mm),    32'(mm));
    chk("z.fv",    32'(z_fv),    32'(fv));
    chk("z.fd",    32'(z_fd),    32'(fd));
  endtask

  // Drive one cycle's inputs, clock it, update the model, then check on the falling edge.
  task automatic cyc(input logic r, input logic st, input logic v,
                     input logic [3:0] iv, input logic [1:0] b, input logic [1:0] s);
    rst = r; start = st; sample_valid = v; in_vec = iv; b_out = b; s_out = s;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic clean();
    logic [1:0] b;
    logic [3:0] iv;
    b = 2'($urandom); iv = 4'($urandom);
    cyc(1'b0, 1'b0, 1'b1, iv, b, b);
  endtask

  task automatic bad();
    logic [1:0] b;
    logic [3:0] iv;
    b = 2'($urandom); iv = 4'($urandom);
    cyc(1'b0, 1'b0, 1'b1, iv, b, ~b);
  endtask

  typedef struct {
    logic r, st, v;
    logic [3:0] iv;
    logic [1:0] b, s;
    logic e_busy, e_done, e_pulse;
    logic [7:0] e_vc, e_mm;
  } vec_t;

  vec_t tbl[10];
  bit   seen_pulse;
  logic xb;
  logic [1:0] xs;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 4'h3, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 4'h0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 4'h5, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 4'h9, 2'b01, 2'b11, 1'b1, 1'b0, 1'b1, 8'd2, 8'd1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 4'h1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 8'd3, 8'd1};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 4'h2, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 4'h4, 2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 8'd1, 8'd1};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 4'h6, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};

    phase = "table";
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].r, tbl[i].st, tbl[i].v, tbl[i].iv, tbl[i].b, tbl[i].s);
      chk("t.busy",  32'(a_busy),  32'(tbl[i].e_busy));
      chk("t.done",  32'(a_done),  32'(tbl[i].e_done));
      chk("t.pulse", 32'(a_pulse), 32'(tbl[i].e_pulse));
      chk("t.vc",    32'(a_vc),    32'(tbl[i].e_vc));
      chk("t.mm",    32'(a_mm),    32'(tbl[i].e_mm));
    end

    phase = "all_match";
    seen_pulse = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 2'b00, 2'b00);
    for (int i = 0; i < 20; i++) begin
      clean();
      seen_pulse |= a_pulse;
    end
    chk("done", 32'(a_done), 32'd1);
    chk("pass", 32'(a_pass), 32'd1);
    chk("vc",   32'(a_vc),   32'd20);
    chk("mm",   32'(a_mm),   32'd0);
    chk("never_pulse", 32'(seen_pulse), 32'd0);

    phase = "single_fault";
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 2'b00, 2'b00);
    for (int i = 1; i <= 20; i++) begin
      if (i == 7) begin
        cyc(1'b0, 1'b0, 1'b1, 4'b1010, 2'b10, 2'b11);
        chk("pulse7", 32'(a_pulse), 32'd1);
        chk("mm7",    32'(a_mm),    32'd1);
      end else clean();
    end
    chk("done", 32'(a_done), 32'd1);
    chk("pass", 32'(a_pass), 32'd0);
    chk("mm",   32'(a_mm),   32'd1);
    chk("fbv",  32'(a_fv),   CAP ? 32'hA : 32'h0);
    chk("fbd",  32'(a_fd),   CAP ? 32'h1 : 32'h0);

    phase = "x_prop";
    xb = 1'bx;
    xs = {1'b1, xb};
    if (!$isunknown(xb)) xs = 2'b11;  // 2-state simulator: substitute a known differing bit
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 2'b00, 2'b00);
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        cyc(1'b0, 1'b0, 1'b1, 4'b0110, 2'b10, xs);
        chk("pulse3", 32'(a_pulse), 32'd1);
      end else clean();
    end
    chk("mm",  32'(a_mm), 32'd1);
    chk("fbd", 32'(a_fd), CAP ? 32'h1 : 32'h0);
    chk("fbv", 32'(a_fv), CAP ? 32'h6 : 32'h0);

    phase = "saturate";
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 2'b00, 2'b00);
    for (int i = 0; i < 20; i++) bad();
    chk("z.mm",   32'(z_mm),   32'd15);
    chk("z.vc",   32'(z_vc),   32'd15);
    chk("z.done", 32'(z_done), 32'd1);
    chk("z.pass", 32'(z_pass), 32'd0);

    phase = "rst_mid";
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) clean();
    bad();
    cyc(1'b1, 1'b1, 1'b1, 4'hF, 2'b00, 2'b11);
    chk("busy", 32'(a_busy), 32'd0);
    chk("vc",   32'(a_vc),   32'd0);
    chk("mm",   32'(a_mm),   32'd0);
    for (int i = 0; i < 3; i++) bad();
    chk("idle_mm", 32'(a_mm), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 2'b00, 2'b00);
    for (int i = 0; i < 20; i++) clean();
    chk("pass", 32'(a_pass), 32'd1);

    phase = "restart";
    for (int i = 0; i < 3; i++) bad();
    chk("hold_vc", 32'(a_vc), 32'd20);
    cyc(1'b0, 1'b1, 1'b1, 4'h7, 2'b01, 2'b10);
    chk("busy",  32'(a_busy),  32'd1);
    chk("vc",    32'(a_vc),    32'd0);
    chk("mm",    32'(a_mm),    32'd0);
    chk("pulse", 32'(a_pulse), 32'd0);

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      logic r, st, v;
      logic [1:0] b, s;
      r  = ($urandom_range(0, 149) == 0);
      st = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 9) < 7);
      b  = 2'($urandom);
      s  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : b;
      cyc(r, st, v, 4'($urandom), b, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
